// File: rtl/qs_feed_scheduler.sv
// rtl/qs_feed_scheduler.sv - four-symbol round-robin feed into a shared in-order pipeline
// Tags each issued sample with its symbol id and halts the feed after a kill result drains.
module qs_feed_scheduler #(
  parameter int MAX_INFLIGHT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_price,
  input  logic [127:0] req_position,
  input  logic [127:0] req_beta,
  output logic         pl_in_valid,
  input  logic         pl_in_ready,
  output logic [31:0]  pl_price,
  output logic [31:0]  pl_position,
  output logic [31:0]  pl_beta,
  input  logic         pl_out_valid,
  output logic         pl_out_ready,
  input  logic [31:0]  pl_signal,
  input  logic         pl_allow,
  input  logic         pl_kill,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_id,
  output logic [31:0]  rsp_signal,
  output logic         rsp_allow,
  output logic         rsp_kill,
  input  logic         halt_clear,
  output logic [1:0]   state,
  output logic [4:0]   inflight,
  output logic         err_sticky
);

  localparam int         PTR_W   = $clog2(MAX_INFLIGHT);
  localparam logic [4:0] MAX_CNT = 5'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [4:0]       inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             err_q, err_d;
  logic [1:0]       tag_q [MAX_INFLIGHT];

  logic       can_issue, grant_found, accept, pop, fifo_empty;
  logic [1:0] grant_id, idx;
  logic [6:0] lsb;

  // First requester at or after the pointer wins, wrapping through 2-bit arithmetic.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    idx         = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // rst_n gates the issue side so valids drop while reset is held, not a cycle later.
  assign can_issue   = rst_n && (state_q == RUN) && (inflight_q < MAX_CNT);
  assign pl_in_valid = can_issue && grant_found;
  assign accept      = pl_in_valid && pl_in_ready;
  assign req_ready   = accept ? (4'b0001 << grant_id) : 4'b0000;
  assign lsb         = {grant_id, 5'd0};
  assign pl_price    = pl_in_valid ? req_price[lsb +: 32]    : 32'd0;
  assign pl_position = pl_in_valid ? req_position[lsb +: 32] : 32'd0;
  assign pl_beta     = pl_in_valid ? req_beta[lsb +: 32]     : 32'd0;

  assign fifo_empty   = (inflight_q == 5'd0);
  assign rsp_valid    = pl_out_valid && !fifo_empty;
  assign pl_out_ready = fifo_empty ? 1'b1 : rsp_ready;
  assign pop          = rsp_valid && rsp_ready;
  assign rsp_id       = tag_q[rd_ptr_q];
  assign rsp_signal   = pl_signal;
  assign rsp_allow    = pl_allow;
  assign rsp_kill     = pl_kill;

  assign state      = state_q;
  assign inflight   = inflight_q;
  assign err_sticky = err_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = accept ? grant_id + 2'd1 : rr_ptr_q;
    inflight_d = inflight_q;
    err_d      = err_q | (pl_out_valid && fifo_empty);
    case ({accept, pop})
      2'b10:   inflight_d = inflight_q + 5'd1;
      2'b01:   inflight_d = inflight_q - 5'd1;
      default: inflight_d = inflight_q;
    endcase
    case (state_q)
      RUN:     if (pop && pl_kill) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = HALT;
      HALT:    if (halt_clear) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) tag_q[wr_ptr_q] <= grant_id;
  end

endmodule
